i2s_playback_tx: RTL

- Playback path: the transmit counterpart of the microphone capture chain.
- Accepts a byte stream from the SPI/FIFO side and packs every 3 bytes, LSB first, into one 24-bit PCM sample. This is the same byte order the capture path writes.
- Serialises each sample as standard Philips I2S (mono, duplicated on both slots) to an external DAC.
- Generates the I2S bit clock and word select itself from the system clock.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_playback_tx_if.sv | 9 +
 rtl/i2s_playback_tx_sample_packer.sv | 59 +++++
 rtl/i2s_playback_tx.sv | 120 ++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S playback path.
package i2s_pkg;

  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2,
    FULL  = 2'd3
  } pack_state_e;

  localparam int unsigned BYTES_PER_SAMPLE = 3;
  localparam int unsigned BYTE_W           = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2s_playback_tx_if.sv
// Byte-stream valid/ready bus feeding the playback transmitter.
interface i2s_playback_tx_if;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_ready_o;

  modport master (output byte_i, output byte_valid_i, input byte_ready_o);
  modport slave  (input byte_i, input byte_valid_i, output byte_ready_o);
endinterface

// File: rtl/i2s_playback_tx_sample_packer.sv
// Packs three LSB-first bytes into one 24-bit sample; holds it until consumed.
module sample_packer
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  input  logic                 consume_i,
  output logic                 full_o,
  output logic [DATA_SIZE-1:0] sample_o
);

  pack_state_e          state_q, state_d;
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic                 xfer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BYTE0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    xfer    = byte_valid_i && byte_ready_o;
    case (state_q)
      BYTE0: if (xfer) begin
        hold_d[0 +: BYTE_W] = byte_i;
        state_d             = BYTE1;
      end
      BYTE1: if (xfer) begin
        hold_d[BYTE_W +: BYTE_W] = byte_i;
        state_d                  = BYTE2;
      end
      BYTE2: if (xfer) begin
        hold_d[2*BYTE_W +: BYTE_W] = byte_i;
        state_d                    = FULL;
      end
      FULL: if (consume_i) begin
        state_d = BYTE0;
      end
      default: state_d = BYTE0;
    endcase
  end

  assign byte_ready_o = (state_q != FULL);
  assign full_o       = (state_q == FULL);
  assign sample_o     = hold_q;

endmodule

// File: rtl/i2s_playback_tx.sv
// Mono Philips-I2S transmitter: bit-clock divider, frame counter and serialiser
// fed by a byte packer; duplicated sample on both slots.
module i2s_playback_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 24,
  parameter int unsigned CLK_DIV   = 32,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  i2s_playback_tx_if.slave   bus,
  output logic               i2s_clk,
  output logic               i2s_ws,
  output logic               i2s_sd,
  output logic               underrun_o,
  output logic [7:0]         underrun_count_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned POS_W = $clog2(2 * SLOT_BITS);
  localparam int unsigned IDX_W = $clog2(DATA_SIZE);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * SLOT_BITS - 1);

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 clk_q, clk_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 ws_q, ws_d;
  logic                 sd_q, sd_d;
  logic [DATA_SIZE-1:0] play_q, play_d;
  logic                 und_q, und_d;
  logic [7:0]           cnt_q, cnt_d;

  logic                 tc, fall, frame_start, consume, full;
  logic [POS_W-1:0]     slot_pos;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_SIZE-1:0] hold;

  sample_packer #(.DATA_SIZE(DATA_SIZE)) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (bus.byte_i),
    .byte_valid_i (bus.byte_valid_i),
    .byte_ready_o (bus.byte_ready_o),
    .consume_i    (consume),
    .full_o       (full),
    .sample_o     (hold)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      clk_q  <= 1'b0;
      pos_q  <= POS_LAST;
      ws_q   <= 1'b0;
      sd_q   <= 1'b0;
      play_q <= '0;
      und_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      div_q  <= div_d;
      clk_q  <= clk_d;
      pos_q  <= pos_d;
      ws_q   <= ws_d;
      sd_q   <= sd_d;
      play_q <= play_d;
      und_q  <= und_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    tc          = (div_q == DIV_W'(CLK_DIV - 1));
    fall        = tc && clk_q;
    frame_start = fall && (pos_q == POS_LAST);
    div_d       = tc ? '0 : div_q + DIV_W'(1);
    clk_d       = clk_q ^ tc;
    pos_d       = pos_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    play_d      = play_q;
    und_d       = 1'b0;
    cnt_d       = cnt_q;
    consume     = 1'b0;
    slot_pos    = '0;
    bit_idx     = '0;

    // Serial data is looked up from the post-advance position so WS and SD
    // update together on the falling bit-clock edge; slot bit 0 stays 0.
    if (fall) begin
      pos_d    = frame_start ? '0 : pos_q + POS_W'(1);
      ws_d     = (pos_d >= POS_W'(SLOT_BITS));
      slot_pos = ws_d ? pos_d - POS_W'(SLOT_BITS) : pos_d;
      if (slot_pos >= POS_W'(1) && slot_pos <= POS_W'(DATA_SIZE)) begin
        bit_idx = IDX_W'(DATA_SIZE - 1) - IDX_W'(slot_pos - POS_W'(1));
        sd_d    = play_q[bit_idx];
      end else begin
        sd_d = 1'b0;
      end
    end

    if (frame_start) begin
      if (full) begin
        consume = 1'b1;
        play_d  = hold;
      end else begin
        play_d = '0;
        und_d  = 1'b1;
        cnt_d  = sat_inc8(cnt_q);
      end
    end
  end

  assign i2s_clk          = clk_q;
  assign i2s_ws           = ws_q;
  assign i2s_sd           = sd_q;
  assign underrun_o       = und_q;
  assign underrun_count_o = cnt_q;

endmodule
